// File: rtl/sobel_stream.sv
// Streaming Sobel edge-magnitude filter: pops raster pixels from an input FIFO and
// pushes one |Gx|+|Gy| pixel per input pixel to an output FIFO, including an end-of-frame flush.
module sobel_stream #(
    parameter int unsigned IMG_WIDTH   = 720,
    parameter int unsigned IMG_HEIGHT  = 540,
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned GRAD_SHIFT  = 0,
    parameter int unsigned BORDER_MODE = 0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              in_rd_en,
    input  logic [DWIDTH-1:0] in_dout,
    input  logic              in_empty,
    output logic              out_wr_en,
    output logic [DWIDTH-1:0] out_din,
    input  logic              out_full
);
    localparam int unsigned W     = IMG_WIDTH;
    localparam int unsigned H     = IMG_HEIGHT;
    localparam int unsigned NPIX  = W * H;
    localparam int unsigned NTAPS = 2 * W + 3;
    localparam int unsigned XW    = $clog2(W);
    localparam int unsigned YW    = $clog2(H);
    localparam int unsigned CW    = $clog2(NPIX);
    localparam int unsigned GW    = DWIDTH + 3;
    localparam int unsigned MW    = DWIDTH + 4;
    localparam int unsigned MAXV  = (1 << DWIDTH) - 1;

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t            state;
    state_t            state_next;
    logic [DWIDTH-1:0] taps [NTAPS];
    logic [XW-1:0]     cx;
    logic [YW-1:0]     cy;
    logic [CW-1:0]     in_cnt;
    logic              advance;
    logic              last_col;
    logic              last_pix;
    logic              border;

    assign last_col = (cx == XW'(W - 1));
    assign last_pix = last_col && (cy == YW'(H - 1));
    assign border   = (cx == '0) || last_col || (cy == '0) || (cy == YW'(H - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= FILL;
        else       state <= state_next;
    end

    // Handshake: an advance needs the FIFOs this state touches to be ready; reset masks all strobes.
    always_comb begin
        state_next = state;
        advance    = 1'b0;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        if (!reset) begin
            case (state)
                FILL: if (!in_empty) begin
                    advance  = 1'b1;
                    in_rd_en = 1'b1;
                    if (in_cnt == CW'(W + 1)) state_next = RUN;
                end
                RUN: if (!in_empty && !out_full) begin
                    advance   = 1'b1;
                    in_rd_en  = 1'b1;
                    out_wr_en = 1'b1;
                    if (in_cnt == CW'(NPIX - 1)) state_next = FLUSH;
                end
                FLUSH: if (!out_full) begin
                    advance   = 1'b1;
                    out_wr_en = 1'b1;
                    if (last_pix) state_next = FILL;
                end
                default: state_next = FILL;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NTAPS); i++) taps[i] <= '0;
        end else if (advance) begin
            for (int i = int'(NTAPS) - 1; i > 0; i--) taps[i] <= taps[i-1];
            taps[0] <= (state == FLUSH) ? '0 : in_dout;
        end
    end

    // cx/cy follow the centre pixel being emitted; the frame wraps on the last flush write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cx     <= '0;
            cy     <= '0;
            in_cnt <= '0;
        end else if (advance) begin
            if (in_rd_en) in_cnt <= (in_cnt == CW'(NPIX - 1)) ? '0 : in_cnt + CW'(1);
            if (state == FLUSH && last_pix) begin
                cx     <= '0;
                cy     <= '0;
                in_cnt <= '0;
            end else if (out_wr_en) begin
                if (last_col) begin
                    cx <= '0;
                    cy <= cy + YW'(1);
                end else begin
                    cx <= cx + XW'(1);
                end
            end
        end
    end

    logic signed [GW-1:0] al, a, ar, l, r, bl, b, br;
    logic signed [GW-1:0] gx, gy;
    logic        [GW-1:0] ax, ay;
    logic        [MW-1:0] sum, mag;

    assign al = GW'(taps[2*W+2]);
    assign a  = GW'(taps[2*W+1]);
    assign ar = GW'(taps[2*W]);
    assign l  = GW'(taps[W+2]);
    assign r  = GW'(taps[W]);
    assign bl = GW'(taps[2]);
    assign b  = GW'(taps[1]);
    assign br = GW'(taps[0]);

    assign gx  = (ar + (r <<< 1) + br) - (al + (l <<< 1) + bl);
    assign gy  = (bl + (b <<< 1) + br) - (al + (a <<< 1) + ar);
    assign ax  = gx[GW-1] ? GW'(-gx) : GW'(gx);
    assign ay  = gy[GW-1] ? GW'(-gy) : GW'(gy);
    assign sum = MW'(ax) + MW'(ay);
    assign mag = sum >> GRAD_SHIFT;

    always_comb begin
        out_din = '0;
        if (border) begin
            if (BORDER_MODE == 1) out_din = taps[W+1];
        end else if (mag > MW'(MAXV)) begin
            out_din = '1;
        end else begin
            out_din = mag[DWIDTH-1:0];
        end
    end
endmodule
